// File: rtl/zoom_line_buffer_if.sv
// Pixel write stream and two-line vertical read port
// of the zoom line buffer.
interface zoom_line_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LINES  = 4
);
  localparam int LW = $clog2(NUM_LINES);

  logic                  sof;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_eol;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_release;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data0;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [LW:0]           lines_avail;
  logic                  wr_overflow;

  modport master (
    output sof, wr_valid, wr_data, wr_eol,
    output rd_en, rd_addr, rd_release,
    input  wr_ready, rd_valid, rd_data0,
    input  rd_data1, lines_avail, wr_overflow
  );

  modport slave (
    input  sof, wr_valid, wr_data, wr_eol,
    input  rd_en, rd_addr, rd_release,
    output wr_ready, rd_valid, rd_data0,
    output rd_data1, lines_avail, wr_overflow
  );
endinterface

// File: rtl/zoom_line_buffer.sv
// Ring of NUM_LINES line RAMs: one line is written while
// the two oldest complete lines are read side by side.
module zoom_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LINES  = 4
) (
  input logic               clk,
  input logic               rst_n,
  zoom_line_buffer_if.slave bus
);
  localparam int LW    = $clog2(NUM_LINES);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [LW:0] FULL = (LW+1)'(NUM_LINES);
  localparam logic [LW:0] TWO  = (LW+1)'(2);

  logic [LW-1:0]         head;
  logic [LW-1:0]         wslot;
  logic [LW-1:0]         mslot;
  logic [LW-1:0]         sel0_q;
  logic [LW-1:0]         sel1_q;
  logic [LW:0]           avail;
  logic [ADDR_WIDTH-1:0] wr_col;
  logic [ADDR_WIDTH-1:0] mcol;
  logic                  ovf;
  logic                  rd_valid;
  logic                  has_line;
  logic                  wr_ok;
  logic                  acc;
  logic                  done;
  logic                  wrap;
  logic                  rel;
  logic                  rd_acc;

  logic [DATA_WIDTH-1:0] mem [NUM_LINES][DEPTH];
  logic [DATA_WIDTH-1:0] q   [NUM_LINES];

  assign has_line = avail != '0;
  assign wr_ok    = avail < FULL;
  assign wslot    = head + avail[LW-1:0];

  // sof forces the pixel into slot 0, column 0
  always_comb begin
    acc    = bus.wr_valid & (wr_ok | bus.sof);
    done   = acc & bus.wr_eol & ~bus.sof;
    wrap   = acc & ~bus.wr_eol & ~bus.sof
           & (wr_col == '1);
    rel    = bus.rd_release & has_line & ~bus.sof;
    rd_acc = bus.rd_en & has_line & ~bus.sof;
    mslot  = bus.sof ? '0 : wslot;
    mcol   = bus.sof ? '0 : wr_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      avail    <= '0;
      wr_col   <= '0;
      ovf      <= 1'b0;
      rd_valid <= 1'b0;
      sel0_q   <= '0;
      sel1_q   <= '0;
    end else if (bus.sof) begin
      head     <= '0;
      avail    <= '0;
      wr_col   <= bus.wr_valid ? ADDR_WIDTH'(1) : '0;
      ovf      <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (acc)
        wr_col <= done ? '0 : wr_col + 1'b1;
      if (wrap)
        ovf <= 1'b1;
      if (rel)
        head <= head + 1'b1;
      case ({done, rel})
        2'b10:   avail <= avail + 1'b1;
        2'b01:   avail <= avail - 1'b1;
        default: ;
      endcase
      rd_valid <= rd_acc;
      // single line left: replicate it as the lower neighbour
      if (rd_acc) begin
        sel0_q <= head;
        sel1_q <= (avail >= TWO) ? head + 1'b1 : head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      mem[mslot][mcol] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_LINES; s++)
        q[s] <= '0;
    end else if (rd_acc) begin
      for (int s = 0; s < NUM_LINES; s++)
        q[s] <= mem[s][bus.rd_addr];
    end
  end

  assign bus.wr_ready    = wr_ok;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_data0    = q[sel0_q];
  assign bus.rd_data1    = q[sel1_q];
  assign bus.lines_avail = avail;
  assign bus.wr_overflow = ovf;
endmodule

// File: tb/tb_zoom_line_buffer.sv
// Random and directed checks of zoom_line_buffer against
// a queue-of-lines model.
module tb_zoom_line_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  zoom_line_buffer_if bus ();

  zoom_line_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mline [0:15][0:2047];
  int          mlen  [0:15];
  int          lq[$];
  int          cur = 0;
  int          col = 0;
  bit          movf = 0;
  bit          ev = 0;
  logic [15:0] e0 = '0;
  logic [15:0] e1 = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic new_line();
    cur = (cur + 1) % 16;
    mlen[cur] = 0;
    col = 0;
  endtask

  task automatic cyc(input bit s, input bit wv,
                     input logic [15:0] d,
                     input bit eol, input bit re,
                     input int addr, input bit rel);
    int avail;
    bus.sof        = s;
    bus.wr_valid   = wv;
    bus.wr_data    = d;
    bus.wr_eol     = eol;
    bus.rd_en      = re;
    bus.rd_addr    = 11'(addr);
    bus.rd_release = rel;
    #1;
    chk("wr_ready_pre", 32'(bus.wr_ready),
        32'(lq.size() < 4));
    avail = lq.size();
    if (s) begin
      ev = 0;
      lq.delete();
      movf = 0;
      new_line();
      if (wv) begin
        mline[cur][0] = d;
        mlen[cur] = 1;
        col = 1;
      end
    end else begin
      if (re && avail > 0) begin
        ev = 1;
        e0 = mline[lq[0]][addr];
        e1 = (avail >= 2) ? mline[lq[1]][addr] : e0;
      end else begin
        ev = 0;
      end
      if (rel && avail > 0)
        void'(lq.pop_front());
      if (wv && avail < 4) begin
        mline[cur][col] = d;
        if (col + 1 > mlen[cur])
          mlen[cur] = col + 1;
        if (eol) begin
          lq.push_back(cur);
          new_line();
        end else if (col == 2047) begin
          movf = 1;
          col = 0;
        end else begin
          col++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
    chk("rd_data0", 32'(bus.rd_data0), 32'(e0));
    chk("rd_data1", 32'(bus.rd_data1), 32'(e1));
    chk("lines_avail", 32'(bus.lines_avail),
        32'(lq.size()));
    chk("wr_overflow", 32'(bus.wr_overflow),
        32'(movf));
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int addr);
    cyc(0, 0, 16'h0, 0, 1, addr, 0);
  endtask

  task automatic rel1();
    cyc(0, 0, 16'h0, 0, 0, 0, 1);
  endtask

  task automatic wline(input logic [15:0] base,
                       input int n);
    for (int c = 0; c < n; c++)
      cyc(0, 1, base + 16'(c), c == n - 1, 0, 0, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.wr_ready), 32'd1);
    chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, "_d0"}, 32'(bus.rd_data0), 32'd0);
    chk({tag, "_d1"}, 32'(bus.rd_data1), 32'd0);
    chk({tag, "_avail"}, 32'(bus.lines_avail), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.wr_overflow), 32'd0);
  endtask

  task automatic rnd_run(input int n);
    int  tgt;
    bit  s, wv, eol, re, rel, acc;
    int  addr, lim;
    tgt = $urandom_range(10, 1);
    for (int i = 0; i < n; i++) begin
      s   = ($urandom_range(99, 0) == 0);
      wv  = ($urandom_range(99, 0) < 60);
      eol = !s && (col + 1 >= tgt);
      re  = $urandom_range(1, 0) == 1;
      rel = ($urandom_range(99, 0) < 15);
      addr = $urandom_range(2047, 0);
      if (lq.size() > 0) begin
        lim = mlen[lq[0]];
        if (lq.size() > 1 && mlen[lq[1]] < lim)
          lim = mlen[lq[1]];
        addr = $urandom_range(lim - 1, 0);
      end
      acc = wv && (lq.size() < 4);
      cyc(s, wv, 16'($urandom), eol, re, addr, rel);
      if (s || (acc && eol))
        tgt = $urandom_range(10, 1);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    lq.delete();
    movf = 0;
    ev = 0;
    e0 = '0;
    e1 = '0;
    new_line();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.sof = 0;
    bus.wr_valid = 0;
    bus.wr_data = '0;
    bus.wr_eol = 0;
    bus.rd_en = 0;
    bus.rd_addr = '0;
    bus.rd_release = 0;
    for (int i = 0; i < 16; i++)
      mlen[i] = 0;
    #2;
    chk_reset("rst");
    #10;
    rst_n = 1'b1;

    // 1: three lines, two-line read
    for (int l = 0; l < 3; l++) begin
      wline(16'h0100 * 16'(l), 8);
      chk("t1_avail", 32'(bus.lines_avail), 32'(l + 1));
    end
    rd(5);
    chk("t1_d0", 32'(bus.rd_data0), 32'h0005);
    chk("t1_d1", 32'(bus.rd_data1), 32'h0105);
    idle();
    chk("t1_vdrop", 32'(bus.rd_valid), 32'd0);

    // 2: full, back-pressure, release, refill
    wline(16'h0300, 8);
    chk("t2_full", 32'(bus.wr_ready), 32'd0);
    cyc(0, 1, 16'h0400, 0, 0, 0, 0);
    rel1();
    chk("t2_ready", 32'(bus.wr_ready), 32'd1);
    wline(16'h0400, 8);
    rd(2);
    chk("t2_d0", 32'(bus.rd_data0), 32'h0102);
    chk("t2_d1", 32'(bus.rd_data1), 32'h0202);

    // 3: single line replicate, empty read
    cyc(1, 1, 16'hA000, 0, 0, 0, 0);
    for (int c = 1; c < 8; c++)
      cyc(0, 1, 16'hA000 + 16'(c), c == 7, 0, 0, 0);
    rd(3);
    chk("t3_d0", 32'(bus.rd_data0), 32'hA003);
    chk("t3_d1", 32'(bus.rd_data1), 32'hA003);
    rel1();
    rd(0);
    chk("t3_empty", 32'(bus.rd_valid), 32'd0);
    chk("t3_hold", 32'(bus.rd_data0), 32'hA003);

    // 4: completion with release, empty release
    wline(16'hC000, 4);
    wline(16'hC100, 4);
    for (int c = 0; c < 3; c++)
      cyc(0, 1, 16'hC200 + 16'(c), 0, 0, 0, 0);
    cyc(0, 1, 16'hC203, 1, 0, 0, 1);
    chk("t4_avail", 32'(bus.lines_avail), 32'd2);
    rd(0);
    chk("t4_d0", 32'(bus.rd_data0), 32'hC100);
    chk("t4_d1", 32'(bus.rd_data1), 32'hC200);
    rel1();
    rel1();
    rel1();
    chk("t4_none", 32'(bus.lines_avail), 32'd0);

    // 5: column wrap
    for (int i = 0; i < 2050; i++)
      cyc(0, 1, 16'(i), 0, 0, 0, 0);
    chk("t5_ovf", 32'(bus.wr_overflow), 32'd1);
    chk("t5_avail", 32'(bus.lines_avail), 32'd0);
    cyc(0, 1, 16'h5A5A, 1, 0, 0, 0);
    rd(2);
    chk("t5_col2", 32'(bus.rd_data0), 32'h5A5A);
    cyc(1, 0, 16'h0, 0, 0, 0, 0);
    chk("t5_clr", 32'(bus.wr_overflow), 32'd0);

    // 6: sof mid-line with reads pending
    wline(16'hD000, 4);
    wline(16'hD100, 4);
    wline(16'hD200, 4);
    cyc(0, 1, 16'hD300, 0, 0, 0, 0);
    cyc(0, 1, 16'hD301, 0, 0, 0, 0);
    cyc(1, 1, 16'hBEEF, 0, 1, 0, 0);
    chk("t6_avail", 32'(bus.lines_avail), 32'd0);
    chk("t6_valid", 32'(bus.rd_valid), 32'd0);
    for (int c = 1; c < 4; c++)
      cyc(0, 1, 16'hBE00 + 16'(c), c == 3, 0, 0, 0);
    rd(0);
    chk("t6_sofpix", 32'(bus.rd_data0), 32'hBEEF);

    rnd_run(2500);
    async_reset();
    rnd_run(800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
